lowmc_key_loader: RTL and testbench
===================================

// Module: lowmc_key_loader
// PURPOSE
//  Downstream of the lowmc_key AXI4-Lite slave register file. It collects 32-bit key words written over AXI-Lite
//  into a staging buffer and tracks which words have been written. On a commit pulse it transfers the complete
//  staged key into a double-buffered output register. It then offers that key to the LowMC core through a
//  valid/ready handshake and exposes a status word for AXI-Lite readback.
// PARAMETERS
//  KEY_WIDTH   128  LowMC key width in bits; multiple of WORD_WIDTH, 32..256 (128 = L1, 192 = L3, 256 = L5)
//  WORD_WIDTH  32   AXI-Lite data word width; fixed at 32
//  WORDS       KEY_WIDTH/WORD_WIDTH (localparam, 1..8); IDX_W = max(1,$clog2(WORDS))
// PORTS
//  Clk_CI       in   1          clock
//  Rst_RI       in   1          synchronous reset, active-high
//  WrEn_SI      in   1          one-cycle key word write strobe from the AXI-Lite slave
//  WrIdx_DI     in   3          word index; valid range 0..WORDS-1
//  WrData_DI    in   32         key word
//  Commit_SI    in   1          one-cycle request to move the staged key to the output
//  Clear_SI     in   1          one-cycle request to clear the staging mask and the error flag
//  Key_DO       out  KEY_WIDTH  key offered to the LowMC core
//  KeyValid_SO  out  1          Key_DO is valid and offered
//  KeyReady_SI  in   1          the LowMC core accepts the key
//  Err_SO       out  1          sticky error flag
//  Status_DO    out  32         [7:0] staging mask, [8] KeyValid_SO, [9] Err_SO, [23:16] accepted-key count, rest 0
// BEHAVIOUR
//  Reset: staging buffer = 0, mask = 0, Key_DO = 0, KeyValid_SO = 0, Err_SO = 0, count = 0, state = FILL.
//  Word order: word i maps to Key[KEY_WIDTH-1-32*i -: 32], so word 0 is the MSB word.
//  Write: WrEn_SI with WrIdx_DI < WORDS stores the word and sets mask[idx]; a rewrite overwrites it.
//   If WrIdx_DI >= WORDS, the write is dropped and Err_SO is set. Writes are accepted in every state.
//  FSM, two states:
//   FILL   KeyValid_SO = 0. A legal commit loads Key_DO from staging, clears the mask, and goes to OFFER.
//          KeyValid_SO rises the next cycle, so commit-to-valid latency is 1 cycle.
//   OFFER  KeyValid_SO = 1, and Key_DO holds stable until the handshake.
//          KeyValid_SO && KeyReady_SI is the handshake: count increments, wrapping 255 -> 0.
//          The next state is FILL, unless a legal commit occurs in the same cycle.
//  Commit legality:
//   - The mask must be all ones over WORDS bits, checked on the pre-cycle mask.
//   - The block must be in FILL, or in OFFER with the handshake occurring in the same cycle.
//   - If both hold: Key_DO reloads and the state is OFFER next cycle.
//     In the back-to-back case KeyValid_SO stays 1, and the new key appears on the cycle after the handshake.
//   - Any other commit is ignored and sets Err_SO. Staging, mask and Key_DO are unchanged.
//  Write in the same cycle as a legal commit: the commit uses pre-write staging.
//   The mask is cleared, and the new word is then written with its mask bit set (mask = 1<<idx).
//  Clear_SI: mask = 0 and Err_SO = 0. Staging data is kept, and OFFER/Key_DO are unaffected (no valid retraction).
//   Clear beats a same-cycle write, which is dropped, and a same-cycle commit, which is ignored without error.
//   Clear beats a same-cycle error source, so Err_SO = 0.
//  KeyValid_SO never drops without a handshake, except on Rst_RI.
//  Rst_RI mid-OFFER: KeyValid_SO = 0 next cycle and all state returns to reset values.
//  All outputs are registered. Status_DO is a registered concatenation with 1-cycle latency.
// TESTING
//  1. Reset, write idx 0..3 = 0x00112233,0x44556677,0x8899AABB,0xCCDDEEFF, then commit.
//     -> KeyValid_SO=1 at commit+1, Key_DO=0x00112233_44556677_8899AABB_CCDDEEFF, mask=0.
//     KeyReady_SI=1 for one cycle -> KeyValid_SO=0, Status_DO[23:16]=1.
//  2. Write idx 0,1,3 only, then commit -> no KeyValid_SO, Err_SO=1, Status_DO[7:0]=0x0B.
//     Then Clear -> Err_SO=0, mask=0.
//  3. Write idx 5 with KEY_WIDTH=128 -> write dropped, Err_SO=1, mask unchanged.
//  4. During OFFER with KeyReady_SI=0 for 20 cycles, rewrite all 4 words (mask=0xF).
//     Then assert commit and KeyReady_SI together -> KeyValid_SO stays 1, and Key_DO shows the new key.
//     Count increments once.
//  5. Commit in OFFER without ready -> Err_SO=1 and Key_DO unchanged.
//     Commit + write idx 2 in the same cycle as a legal commit -> mask=0x04 afterwards.
//  6. Assert Rst_RI mid-OFFER -> KeyValid_SO=0, Key_DO=0, Status_DO=0 next cycle.
//     255 handshakes -> count wraps to 0 on the 256th.

Source files
------------

// File: rtl/lowmc_key_loader.sv
// ============================================================================
//  Module   : lowmc_key_loader
//  Purpose  : Stages AXI-Lite key words, commits complete keys into a held
//             output register and offers them to the LowMC core (valid/ready).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module lowmc_key_loader #(
    parameter int KEY_WIDTH  = 128,
    parameter int WORD_WIDTH = 32
) (
    input  logic                 Clk_CI,
    input  logic                 Rst_RI,
    input  logic                 WrEn_SI,
    input  logic [2:0]           WrIdx_DI,
    input  logic [31:0]          WrData_DI,
    input  logic                 Commit_SI,
    input  logic                 Clear_SI,
    output logic [KEY_WIDTH-1:0] Key_DO,
    output logic                 KeyValid_SO,
    input  logic                 KeyReady_SI,
    output logic                 Err_SO,
    output logic [31:0]          Status_DO
);

    localparam int WORDS = KEY_WIDTH / WORD_WIDTH;
    localparam logic [3:0] C_WORDS = 4'(WORDS);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_OFFER = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   staging_q, staging_d;
    logic [WORDS-1:0]       mask_q, mask_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic                   err_q, err_d;
    logic [7:0]             count_q, count_d;
    logic [31:0]            status_q, status_d;

    logic w_idx_ok;
    logic w_wr_legal;
    logic w_wr_bad;
    logic w_handshake;
    logic w_mask_full;
    logic w_commit_ok;
    logic w_commit_bad;

    assign w_idx_ok     = ({1'b0, WrIdx_DI} < C_WORDS);
    assign w_wr_legal   = WrEn_SI && w_idx_ok && !Clear_SI;
    assign w_wr_bad     = WrEn_SI && !w_idx_ok;
    assign w_handshake  = (state_q == ST_OFFER) && KeyReady_SI;
    assign w_mask_full  = (mask_q == {WORDS{1'b1}});
    // Clear suppresses a same-cycle commit silently, so it is excluded from both terms.
    assign w_commit_ok  = Commit_SI && !Clear_SI && w_mask_full
                          && ((state_q == ST_FILL) || w_handshake);
    assign w_commit_bad = Commit_SI && !Clear_SI && !w_commit_ok;

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        mask_d    = mask_q;
        key_d     = key_q;
        err_d     = err_q;
        count_d   = count_q;

        if (w_commit_ok) begin
            key_d  = staging_q;
            mask_d = '0;
        end

        // Word 0 is the most significant word of the key.
        for (int i = 0; i < WORDS; i++) begin
            if (w_wr_legal && (WrIdx_DI == 3'(i))) begin
                staging_d[KEY_WIDTH-1-WORD_WIDTH*i -: WORD_WIDTH] = WrData_DI;
                mask_d[i] = 1'b1;
            end
        end

        if (Clear_SI) begin
            mask_d = '0;
            err_d  = 1'b0;
        end else if (w_wr_bad || w_commit_bad) begin
            err_d = 1'b1;
        end

        if (w_handshake) begin
            count_d = count_q + 8'd1;
        end

        case (state_q)
            ST_FILL: begin
                if (w_commit_ok) state_d = ST_OFFER;
            end
            ST_OFFER: begin
                if (w_handshake && !w_commit_ok) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase

        status_d        = '0;
        status_d[7:0]   = 8'(mask_q);
        status_d[8]     = (state_q == ST_OFFER);
        status_d[9]     = err_q;
        status_d[23:16] = count_q;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q   <= ST_FILL;
            staging_q <= '0;
            mask_q    <= '0;
            key_q     <= '0;
            err_q     <= 1'b0;
            count_q   <= 8'd0;
            status_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            staging_q <= staging_d;
            mask_q    <= mask_d;
            key_q     <= key_d;
            err_q     <= err_d;
            count_q   <= count_d;
            status_q  <= status_d;
        end
    end

    assign Key_DO      = key_q;
    assign KeyValid_SO = (state_q == ST_OFFER);
    assign Err_SO      = err_q;
    assign Status_DO   = status_q;

endmodule

`default_nettype wire

// File: tb/tb_lowmc_key_loader.sv
// ============================================================================
//  Module   : tb_lowmc_key_loader
//  Purpose  : Directed self-checking bench for lowmc_key_loader (KEY_WIDTH=128).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lowmc_key_loader;

    logic         clk;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_idx;
    logic [31:0]  wr_data;
    logic         commit;
    logic         clear;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         err;
    logic [31:0]  status;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] C_K1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] C_K2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam logic [127:0] C_K3 = 128'h11111111_22222222_33333333_44444444;

    lowmc_key_loader #(.KEY_WIDTH(128), .WORD_WIDTH(32)) dut (
        .Clk_CI      (clk),
        .Rst_RI      (rst),
        .WrEn_SI     (wr_en),
        .WrIdx_DI    (wr_idx),
        .WrData_DI   (wr_data),
        .Commit_SI   (commit),
        .Clear_SI    (clear),
        .Key_DO      (key),
        .KeyValid_SO (key_valid),
        .KeyReady_SI (key_ready),
        .Err_SO      (err),
        .Status_DO   (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] idx, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic write_key(input logic [127:0] k);
        logic [127:0] kv;
        kv = k;
        write_word(3'd0, kv[127:96]);
        write_word(3'd1, kv[95:64]);
        write_word(3'd2, kv[63:32]);
        write_word(3'd3, kv[31:0]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
        checks++;
        if (key !== 128'd0) begin errors++; $display("FAIL reset_key: got %h want 0", key); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++;
        if (status !== 32'd0) begin errors++; $display("FAIL reset_status: got %h want 0", status); end
    endtask

    task automatic test_basic();
        write_key(C_K1);
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_prevalid: got %b want 0", key_valid); end
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", key_valid); end
        checks++;
        if (key !== C_K1) begin errors++; $display("FAIL basic_key: got %h want %h", key, C_K1); end
        tick();
        checks++;
        if (status !== 32'h0000_0100) begin errors++; $display("FAIL basic_status_offer: got %h want 00000100", status); end
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL basic_drop: got %b want 0", key_valid); end
        tick();
        checks++;
        if (status !== 32'h0001_0000) begin errors++; $display("FAIL basic_count: got %h want 00010000", status); end
    endtask

    task automatic test_incomplete();
        write_word(3'd0, 32'hA0A0A0A0);
        write_word(3'd1, 32'hA1A1A1A1);
        write_word(3'd3, 32'hA3A3A3A3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL incomplete_valid: got %b want 0", key_valid); end
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL incomplete_err: got %b want 1", err); end
        tick();
        checks++;
        if (status !== 32'h0001_020B) begin errors++; $display("FAIL incomplete_status: got %h want 0001020B", status); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b want 0", err); end
        tick();
        checks++;
        if (status !== 32'h0001_0000) begin errors++; $display("FAIL clear_status: got %h want 00010000", status); end
    endtask

    task automatic test_bad_index();
        write_word(3'd0, 32'h12345678);
        write_word(3'd5, 32'h87654321);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL badidx_err: got %b want 1", err); end
        tick();
        checks++;
        if (status !== 32'h0001_0201) begin errors++; $display("FAIL badidx_status: got %h want 00010201", status); end
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_clear_priority();
        write_key(C_K3);
        // Clear with a commit and an out-of-range write: nothing happens, no error.
        clear   = 1'b1;
        commit  = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 3'd7;
        wr_data = 32'hFFFFFFFF;
        tick();
        clear  = 1'b0;
        commit = 1'b0;
        wr_en  = 1'b0;
        checks++;
        if ({key_valid, err} !== 2'b00) begin errors++; $display("FAIL clrprio_valid_err: got %b want 00", {key_valid, err}); end
        tick();
        checks++;
        if (status !== 32'h0001_0000) begin errors++; $display("FAIL clrprio_status: got %h want 00010000", status); end
    endtask

    task automatic test_back_to_back();
        write_key(C_K1);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        write_key(C_K2);
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if (key_valid !== 1'b1 || key !== C_K1) begin
                errors++;
                $display("FAIL b2b_hold[%0d]: got valid=%b key=%h want 1 %h", i, key_valid, key, C_K1);
            end
        end
        commit    = 1'b1;
        key_ready = 1'b1;
        tick();
        commit    = 1'b0;
        key_ready = 1'b0;
        checks++;
        if (key_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", key_valid); end
        checks++;
        if (key !== C_K2) begin errors++; $display("FAIL b2b_key: got %h want %h", key, C_K2); end
        tick();
        checks++;
        if (status !== 32'h0002_0100) begin errors++; $display("FAIL b2b_status: got %h want 00020100", status); end
    endtask

    task automatic test_commit_errors();
        // Offering C_K2; a full mask does not make a commit legal without ready.
        write_key(C_K3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL offer_commit_err: got %b want 1", err); end
        checks++;
        if (key !== C_K2 || key_valid !== 1'b1) begin
            errors++;
            $display("FAIL offer_commit_key: got valid=%b key=%h want 1 %h", key_valid, key, C_K2);
        end
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        write_key(C_K3);
        // Legal commit with a same-cycle write: commit takes pre-write staging.
        commit  = 1'b1;
        wr_en   = 1'b1;
        wr_idx  = 3'd2;
        wr_data = 32'h5A5A5A5A;
        tick();
        commit = 1'b0;
        wr_en  = 1'b0;
        checks++;
        if (key !== C_K3) begin errors++; $display("FAIL cw_key: got %h want %h", key, C_K3); end
        tick();
        checks++;
        if (status !== 32'h0003_0104) begin errors++; $display("FAIL cw_status: got %h want 00030104", status); end
    endtask

    task automatic test_reset_mid_offer();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_offer_valid: got %b want 0", key_valid); end
        checks++;
        if (key !== 128'd0) begin errors++; $display("FAIL rst_offer_key: got %h want 0", key); end
        checks++;
        if (status !== 32'd0) begin errors++; $display("FAIL rst_offer_status: got %h want 0", status); end
    endtask

    task automatic one_round();
        write_key(C_K1);
        commit = 1'b1;
        tick();
        commit    = 1'b0;
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 255; i++) one_round();
        tick();
        checks++;
        if (status[23:16] !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", status[23:16]); end
        one_round();
        tick();
        checks++;
        if (status[23:16] !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", status[23:16]); end
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_idx    = 3'd0;
        wr_data   = 32'd0;
        commit    = 1'b0;
        clear     = 1'b0;
        key_ready = 1'b0;
        test_reset();
        test_basic();
        test_incomplete();
        test_bad_index();
        test_clear_priority();
        test_back_to_back();
        test_commit_errors();
        test_reset_mid_offer();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
